// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end: decodes SS_n-framed MOSI command words for the RAM side
// and serialises RAM read data back out on MISO.
module spi_slave_ctrl #(
  parameter int unsigned FRAME_W = 10,
  parameter int unsigned DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
);

  localparam int unsigned      CNT_W    = 4;
  localparam logic [CNT_W-1:0] RX_LAST  = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHK_CMD, S_WRITE, S_READ_ADD, S_READ_DATA
  } state_t;

  typedef enum logic [1:0] {
    TX_WAIT, TX_SHIFT, TX_FLUSH, TX_DONE
  } tx_ph_t;

  state_t             r_state;
  tx_ph_t             r_tx_ph;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [FRAME_W-2:0] r_rx_sr;
  logic [FRAME_W-1:0] r_rx_data;
  logic               r_rx_valid;
  logic               r_frame_done;
  logic               r_rd_addr_done;
  logic [DATA_W-1:0]  r_tx_sr;
  logic               r_miso;

  logic w_abort;
  logic w_tx_phase;

  assign w_abort    = SS_n && (r_state != S_IDLE);
  // Transmit side only wakes up once the rx_valid cycle of a READ_DATA frame is over
  assign w_tx_phase = (r_state == S_READ_DATA) && r_frame_done && !r_rx_valid;

  assign MISO     = r_miso;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_tx_ph        <= TX_WAIT;
      r_bit_cnt      <= '0;
      r_rx_sr        <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_frame_done   <= 1'b0;
      r_rd_addr_done <= 1'b0;
      r_tx_sr        <= '0;
      r_miso         <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_abort) begin
        // Partial frames are dropped; a finished read-data shift still clears the flag
        r_state   <= S_IDLE;
        r_bit_cnt <= '0;
        r_miso    <= 1'b0;
        if (r_state == S_READ_DATA && r_tx_ph == TX_FLUSH) begin
          r_rd_addr_done <= 1'b0;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (!SS_n) begin
              r_state      <= S_CHK_CMD;
              r_bit_cnt    <= '0;
              r_frame_done <= 1'b0;
              r_tx_ph      <= TX_WAIT;
            end
          end
          S_CHK_CMD: begin
            r_rx_sr   <= {r_rx_sr[FRAME_W-3:0], MOSI};
            r_bit_cnt <= CNT_W'(1);
            if (!MOSI) begin
              r_state <= S_WRITE;
            end else if (r_rd_addr_done) begin
              r_state <= S_READ_DATA;
            end else begin
              r_state <= S_READ_ADD;
            end
          end
          S_WRITE, S_READ_ADD, S_READ_DATA: begin
            if (!r_frame_done) begin
              if (r_bit_cnt == RX_LAST) begin
                r_rx_data    <= {r_rx_sr, MOSI};
                r_rx_valid   <= 1'b1;
                r_frame_done <= 1'b1;
                r_bit_cnt    <= '0;
                if (r_state == S_READ_ADD) begin
                  r_rd_addr_done <= 1'b1;
                end
              end else begin
                r_rx_sr   <= {r_rx_sr[FRAME_W-3:0], MOSI};
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              end
            end else if (w_tx_phase) begin
              case (r_tx_ph)
                TX_WAIT: begin
                  if (tx_valid) begin
                    r_tx_sr <= tx_data;
                    r_tx_ph <= TX_SHIFT;
                  end
                end
                TX_SHIFT: begin
                  r_miso  <= r_tx_sr[DATA_W-1];
                  r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
                  if (r_bit_cnt == TX_LAST) begin
                    r_tx_ph <= TX_FLUSH;
                  end else begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                  end
                end
                TX_FLUSH: begin
                  r_miso         <= 1'b0;
                  r_rd_addr_done <= 1'b0;
                  r_tx_ph        <= TX_DONE;
                end
                default: begin
                  r_tx_ph <= TX_DONE;
                end
              endcase
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Scoreboard bench for spi_slave_ctrl: a transaction-level driver queues expected
// frames and MISO bits, an independent negedge monitor pops and compares them.
module tb_spi_slave_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  spi_slave_ctrl #(.FRAME_W(10), .DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] w;
    int         e;
  } rx_exp_t;

  rx_exp_t exp_rx[$];
  logic    exp_miso_q[$];
  logic    miso_plan[$];
  int      edge_cnt = 0;
  int      checks   = 0;
  int      failures = 0;
  bit      rd_done  = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: one expected MISO value per driven cycle, one expected frame per rx_valid
  always @(negedge clk) begin
    logic    em;
    rx_exp_t er;
    if (exp_miso_q.size() > 0) begin
      em = exp_miso_q.pop_front();
      checks++;
      if (MISO !== em) begin
        failures++;
        $display("FAIL miso edge=%0d got=%b exp=%b", edge_cnt, MISO, em);
      end
    end
    if (rx_valid === 1'b1) begin
      checks++;
      if (exp_rx.size() == 0) begin
        failures++;
        $display("FAIL rx_spurious edge=%0d got rx_data=%h exp no rx_valid", edge_cnt, rx_data);
      end else begin
        er = exp_rx.pop_front();
        if (rx_data !== er.w || edge_cnt != er.e) begin
          failures++;
          $display("FAIL rx_frame got data=%h edge=%0d exp data=%h edge=%0d",
                   rx_data, edge_cnt, er.w, er.e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [7:0] rby();
    return 8'($urandom);
  endfunction

  // One clock of stimulus plus the expectation it implies for the edge it lands on
  task automatic tick(input logic rst, input logic ss, input logic mosi, input logic txv,
                      input logic [7:0] txd, input bit accept, input bit rxpush,
                      input logic [9:0] rxw);
    rst_n = ~rst; SS_n = ss; MOSI = mosi; tx_valid = txv; tx_data = txd;
    @(posedge clk);
    #1;
    if (rst || ss) begin
      miso_plan.delete();
      exp_miso_q.push_back(1'b0);
    end else if (miso_plan.size() > 0) begin
      exp_miso_q.push_back(miso_plan.pop_front());
    end else begin
      exp_miso_q.push_back(1'b0);
    end
    if (accept) for (int i = 7; i >= 0; i--) miso_plan.push_back(txd[i]);
    if (rxpush) exp_rx.push_back('{w: rxw, e: edge_cnt});
    @(negedge clk);
  endtask

  // abort_at: frame bits sent before SS_n rises (-1 = full frame)
  // tx_stop: cycles of shifting before SS_n abort or reset (0 = run to completion)
  task automatic xact(input logic [1:0] cmd, input logic [7:0] pay, input int abort_at,
                      input bit do_tx, input logic [7:0] txd, input int tx_stop,
                      input bit stop_rst, input bit spur);
    logic [9:0] f;
    bit         rd_data;
    f       = {cmd, pay};
    rd_data = cmd[1] && rd_done;
    tick(0, 0, rb(), spur & rb(), rby(), 0, 0, '0);
    for (int i = 9; i >= 0; i--) begin
      if (abort_at == 9 - i) begin
        tick(0, 1, rb(), rb(), rby(), 0, 0, '0);
        return;
      end
      tick(0, 0, f[i], spur & rb(), rby(), 0, (i == 0), f);
    end
    if (cmd[1] && !rd_done) rd_done = 1'b1;
    tick(0, 0, rb(), 1'b0, rby(), 0, 0, '0);
    repeat ($urandom_range(0, 3)) tick(0, 0, rb(), rd_data ? 1'b0 : rb(), rby(), 0, 0, '0);
    if (rd_data && do_tx) begin
      tick(0, 0, rb(), 1'b1, txd, 1, 0, '0);
      for (int j = 0; j < ((tx_stop > 0) ? tx_stop : 10); j++)
        tick(0, 0, rb(), spur & rb(), rby(), 0, 0, '0);
      if (tx_stop == 0) begin
        rd_done = 1'b0;
      end else if (stop_rst) begin
        tick(1, 1, 1'b0, 1'b0, 8'h00, 0, 0, '0);
        rd_done = 1'b0;
        chk("rst_rx_data", 32'(rx_data), 32'h0);
        chk("rst_rx_valid", 32'(rx_valid), 32'h0);
        return;
      end
    end
    tick(0, 1, rb(), rb(), rby(), 0, 0, '0);
    repeat ($urandom_range(0, 2)) tick(0, 1, rb(), rb(), rby(), 0, 0, '0);
  endtask

  initial begin
    logic [1:0] cmd;
    int         ab;
    int         ts;
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_miso", 32'(MISO), 32'h0);
    chk("reset_rx_valid", 32'(rx_valid), 32'h0);
    chk("reset_rx_data", 32'(rx_data), 32'h0);
    tick(0, 1, 1'b0, 1'b0, 8'h00, 0, 0, '0);

    // Write address, write data
    xact(2'b00, 8'hA5, -1, 0, 8'h00, 0, 0, 0);
    xact(2'b01, 8'h3C, -1, 0, 8'h00, 0, 0, 0);
    // Read address then read data returning C3
    xact(2'b10, 8'h07, -1, 0, 8'h00, 0, 0, 0);
    xact(2'b11, rby(), -1, 1, 8'hC3, 0, 0, 0);
    // Abort after 5 bits, then a clean frame; abort on the bit-0 edge
    xact(2'b00, 8'h5A, 5, 0, 8'h00, 0, 0, 0);
    xact(2'b01, 8'h99, -1, 0, 8'h00, 0, 0, 0);
    xact(2'b01, 8'hF0, 9, 0, 8'h00, 0, 0, 0);
    // Spurious tx_valid everywhere except the legitimate strobe
    xact(2'b10, 8'h11, -1, 1, 8'h00, 0, 0, 1);
    xact(2'b11, 8'h22, -1, 1, 8'h96, 0, 0, 1);
    // Aborted read-data keeps the address; next read goes straight to data
    xact(2'b10, 8'h33, -1, 0, 8'h00, 0, 0, 0);
    xact(2'b11, 8'h44, -1, 1, 8'hA7, 3, 0, 0);
    xact(2'b11, 8'h55, -1, 1, 8'h6D, 0, 0, 0);
    // Reset while MISO shows bit 3, then a read command must be an address again
    xact(2'b10, 8'h66, -1, 0, 8'h00, 0, 0, 0);
    xact(2'b11, 8'h77, -1, 1, 8'hE1, 5, 1, 0);
    xact(2'b11, 8'h88, -1, 1, 8'hFF, 0, 0, 1);
    xact(2'b10, 8'h99, -1, 1, 8'h5B, 0, 0, 1);

    for (int n = 0; n < 80; n++) begin
      cmd = 2'($urandom);
      ab  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) : -1;
      ts  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 0;
      xact(cmd, rby(), ab, ($urandom_range(0, 4) != 0), rby(), ts, 0, 1);
    end

    repeat (3) tick(0, 1, 1'b0, 1'b0, 8'h00, 0, 0, '0);
    @(negedge clk);
    chk("rx_queue_drained", 32'(exp_rx.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
